// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a handshaked divisor update that is deferred to the period boundary.
// Build option: define CLK_DIV_CTRL_CLAMP_EN to clamp divisors below 2 instead of rejecting them with err.
module clk_div_ctrl #(
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clock_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter, counter_nxt;
  logic [WIDTH-1:0] div_pending, pending_nxt;
  logic [WIDTH-1:0] active_nxt;
  logic [WIDTH-1:0] div_req;
  logic             clock_nxt, tick_nxt, err_nxt;
  logic             xfer, req_ok, wrap;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      div_active  <= DEFAULT_DIV;
      div_pending <= DEFAULT_DIV;
      clock_out   <= 1'b0;
      tick        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      counter     <= counter_nxt;
      div_active  <= active_nxt;
      div_pending <= pending_nxt;
      clock_out   <= clock_nxt;
      tick        <= tick_nxt;
      err         <= err_nxt;
    end
  end

  always_comb begin
    // Dropping enable in RUN/PEND masks the handshake so no divisor is lost on the way to IDLE.
    div_ready = (state == IDLE) || ((state == RUN) && enable);
    xfer      = div_valid && div_ready;
`ifdef CLK_DIV_CTRL_CLAMP_EN
    div_req   = clamp_div(div_in);
    req_ok    = 1'b1;
`else
    div_req   = div_in;
    req_ok    = (clamp_div(div_in) == div_in);
`endif
    wrap        = (counter == div_active - ONE);
    state_nxt   = state;
    counter_nxt = counter;
    active_nxt  = div_active;
    pending_nxt = div_pending;
    clock_nxt   = 1'b0;
    tick_nxt    = 1'b0;
    err_nxt     = xfer && !req_ok;

    case (state)
      IDLE: begin
        counter_nxt = '0;
        if (xfer && req_ok) begin
          active_nxt  = div_req;
          pending_nxt = div_req;
        end
        if (enable) state_nxt = RUN;
      end
      RUN, PEND: begin
        if (!enable) begin
          state_nxt   = IDLE;
          counter_nxt = '0;
          if (state == PEND) active_nxt = div_pending;
        end else begin
          clock_nxt   = (counter < (div_active >> 1));
          tick_nxt    = wrap;
          counter_nxt = wrap ? '0 : counter + ONE;
          // A divisor accepted on the wrap cycle still waits for the following wrap.
          if ((state == RUN) && xfer && req_ok) begin
            pending_nxt = div_req;
            state_nxt   = PEND;
          end else if ((state == PEND) && wrap) begin
            active_nxt = div_pending;
            state_nxt  = RUN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: default divisor, odd divisor, deferred update,
// illegal divisor, enable drop while pending, and asynchronous reset mid-period.
module tb_clk_div_ctrl;

  localparam int WIDTH = 28;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_valid = 1'b0;
  logic             div_ready;
  logic             clock_out;
  logic             tick;
  logic [WIDTH-1:0] div_active;
  logic             err;

  int n_total = 0;
  int n_pass  = 0;

  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(28'd2)) dut (
    .clock_in  (clk),
    .reset     (reset),
    .enable    (enable),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clock_out (clock_out),
    .tick      (tick),
    .div_active(div_active),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_co", clock_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", div_ready, 1);
    chk("rst_active", div_active, 2);
    cyc();
    #3 reset = 1'b0;

    // Default divisor 2
    enable = 1'b1;
    cyc();
    chk("a_start_co", clock_out, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("a_co", clock_out, (i % 2) == 0);
      chk("a_tick", tick, (i % 2) == 1);
    end
    chk("a_active", div_active, 2);

    // Divisor 5 loaded in IDLE
    enable = 1'b0;
    cyc();
    chk("b_idle_co", clock_out, 0);
    div_in = 5; div_valid = 1'b1;
    chk("b_ready", div_ready, 1);
    cyc();
    div_valid = 1'b0;
    chk("b_active", div_active, 5);
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("b_co", clock_out, (i % 5) < 2);
      chk("b_tick", tick, (i % 5) == 4);
    end

    // Divisor 8, change to 4 at counter 3
    enable = 1'b0;
    cyc();
    enable = 1'b1; div_in = 8; div_valid = 1'b1;
    cyc();
    div_valid = 1'b0;
    chk("c_active8", div_active, 8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("c_co_pre", clock_out, 1);
    end
    div_in = 4; div_valid = 1'b1;
    chk("c_ready_run", div_ready, 1);
    cyc();
    div_valid = 1'b0;
    chk("c_co3", clock_out, 1);
    chk("c_ready_pend", div_ready, 0);
    for (int i = 4; i < 8; i++) begin
      cyc();
      chk("c_co_tail", clock_out, 0);
      chk("c_tick_tail", tick, i == 7);
      chk("c_ready_tail", div_ready, i == 7);
      chk("c_active_tail", div_active, (i == 7) ? 4 : 8);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("c_co4", clock_out, i < 2);
      chk("c_tick4", tick, i == 3);
    end

    // Illegal divisor 1
    div_in = 1; div_valid = 1'b1;
    cyc();
    div_valid = 1'b0;
`ifdef CLK_DIV_CTRL_CLAMP_EN
    chk("d_err", err, 0);
`else
    chk("d_err", err, 1);
    chk("d_ready", div_ready, 1);
`endif
    cyc();
    chk("d_err_clr", err, 0);
    for (int i = 0; i < 4; i++) cyc();
`ifdef CLK_DIV_CTRL_CLAMP_EN
    chk("d_active", div_active, 2);
`else
    chk("d_active", div_active, 4);
`endif

    // Enable dropped in PEND: D=6 running, 10 pending
    enable = 1'b0;
    cyc();
    enable = 1'b1; div_in = 6; div_valid = 1'b1;
    cyc();
    div_valid = 1'b0;
    cyc();
    cyc();
    div_in = 10; div_valid = 1'b1;
    chk("e_ready_run", div_ready, 1);
    cyc();
    div_valid = 1'b0;
    chk("e_ready_pend", div_ready, 0);
    chk("e_active6", div_active, 6);
    enable = 1'b0;
    cyc();
    chk("e_co", clock_out, 0);
    chk("e_tick", tick, 0);
    chk("e_active10", div_active, 10);
    chk("e_ready_idle", div_ready, 1);
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("e_co10", clock_out, i < 5);
      chk("e_tick10", tick, i == 9);
    end

    // Reset mid-period: D=7 running, 3 pending
    enable = 1'b0;
    cyc();
    enable = 1'b1; div_in = 7; div_valid = 1'b1;
    cyc();
    div_in = 3;
    cyc();
    div_valid = 1'b0;
    chk("f_ready_pend", div_ready, 0);
    cyc();
    chk("f_co_pre", clock_out, 1);
    chk("f_active7", div_active, 7);
    #1 reset = 1'b1;
    #1;
    chk("f_co", clock_out, 0);
    chk("f_tick", tick, 0);
    chk("f_active", div_active, 2);
    chk("f_ready", div_ready, 1);
    #3 reset = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("f_co2", clock_out, (i % 2) == 0);
      chk("f_tick2", tick, (i % 2) == 1);
    end
    chk("f_active_end", div_active, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
